// File: rtl/ibex_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Addresses compare on bits [3:0] only when RV32E is enabled.
package ibex_pkg;

  localparam int unsigned RfWbDepthMax = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_wr_req_t;

  function automatic logic rf_addr_eq(input logic [4:0] a, input logic [4:0] b,
                                      input logic rv32e);
    return rv32e ? (a[3:0] == b[3:0]) : (a == b);
  endfunction

  function automatic logic rf_addr_is_x0(input logic [4:0] a, input logic rv32e);
    return rv32e ? (a[3:0] == 4'd0) : (a == 5'd0);
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Circular buffer of pending load writebacks with address-match cancel
// and per-entry read-address match vectors.
module ibex_rf_wb_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned Depth     = 2,
  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            push_i,
  input  logic [4:0]                      push_addr_i,
  input  logic [DataWidth-1:0]            push_data_i,
  input  logic                            pop_i,
  input  logic                            cancel_i,
  input  logic [4:0]                      cancel_addr_i,
  input  logic [4:0]                      raddr_a_i,
  input  logic [4:0]                      raddr_b_i,
  output logic                            head_valid_o,
  output logic [4:0]                      head_addr_o,
  output logic [DataWidth-1:0]            head_data_o,
  output logic [CntW-1:0]                 count_o,
  output logic [PtrW-1:0]                 head_ptr_o,
  output logic [Depth-1:0][DataWidth-1:0] entry_data_o,
  output logic [Depth-1:0]                match_a_o,
  output logic [Depth-1:0]                match_b_o
);

  logic [Depth-1:0]                r_valid;
  logic [Depth-1:0][4:0]           r_addr;
  logic [Depth-1:0][DataWidth-1:0] r_data;
  logic [PtrW-1:0]                 r_head;
  logic [PtrW-1:0]                 r_tail;
  logic [CntW-1:0]                 r_count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Cancelled entries keep their slot and later pop as an idle cycle.
      for (int unsigned i = 0; i < Depth; i++) begin
        if (cancel_i && rf_addr_eq(r_addr[i], cancel_addr_i, RV32E)) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (push_i) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= push_addr_i;
        r_data[r_tail]  <= push_data_i;
        r_tail          <= ptr_inc(r_tail);
      end
      if (pop_i) begin
        r_head <= ptr_inc(r_head);
      end
      r_count <= r_count + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_comb begin
    match_a_o = '0;
    match_b_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      match_a_o[i] = r_valid[i] && rf_addr_eq(r_addr[i], raddr_a_i, RV32E) &&
                     !rf_addr_is_x0(raddr_a_i, RV32E);
      match_b_o[i] = r_valid[i] && rf_addr_eq(r_addr[i], raddr_b_i, RV32E) &&
                     !rf_addr_is_x0(raddr_b_i, RV32E);
    end
  end

  assign head_valid_o = r_valid[r_head];
  assign head_addr_o  = r_addr[r_head];
  assign head_data_o  = r_data[r_head];
  assign count_o      = r_count;
  assign head_ptr_o   = r_head;
  assign entry_data_o = r_data;

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Merges execute and load writebacks onto register file port W1.
// Define IBEX_RF_WB_FWD_EN to forward pending writes to the two read ports.
module ibex_rf_write_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned LsuDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_hit_a_o,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_data_a_o,
  output logic [DataWidth-1:0] fwd_data_b_o,
  output logic                 busy_o
);

  localparam int unsigned Depth = (LsuDepth < 1) ? 1 :
                                  (LsuDepth > RfWbDepthMax) ? RfWbDepthMax : LsuDepth;
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic                            w_head_valid;
  logic [4:0]                      w_head_addr;
  logic [DataWidth-1:0]            w_head_data;
  logic [CntW-1:0]                 w_count;
  logic [PtrW-1:0]                 w_head_ptr;
  logic [Depth-1:0][DataWidth-1:0] w_entry_data;
  logic [Depth-1:0]                w_match_a;
  logic [Depth-1:0]                w_match_b;
  logic [4:0]                      w_fifo_raddr_a;
  logic [4:0]                      w_fifo_raddr_b;

  logic                 w_ex_wr;
  logic                 w_lsu_acc;
  logic                 w_lsu_drop;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_nxt_we;
  logic [4:0]           w_nxt_addr;
  logic [DataWidth-1:0] w_nxt_data;

  logic                 r_rf_we;
  logic [4:0]           r_rf_waddr;
  logic [DataWidth-1:0] r_rf_wdata;

  assign lsu_ready_o = (w_count < CntW'(Depth));
  assign w_empty     = (w_count == '0);
  assign w_ex_wr     = ex_valid_i && !rf_addr_is_x0(ex_waddr_i, RV32E);
  assign w_lsu_acc   = lsu_valid_i && lsu_ready_o;
  // A same-cycle execute write to the same register supersedes the load.
  assign w_lsu_drop  = rf_addr_is_x0(lsu_waddr_i, RV32E) ||
                       (w_ex_wr && rf_addr_eq(lsu_waddr_i, ex_waddr_i, RV32E));
  assign w_pop       = !ex_valid_i && !w_empty;
  assign w_bypass    = !ex_valid_i && w_empty && w_lsu_acc;
  assign w_push      = w_lsu_acc && !w_lsu_drop && !w_bypass;

  ibex_rf_wb_fifo #(
    .DataWidth (DataWidth),
    .RV32E     (RV32E),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (w_push),
    .push_addr_i   (lsu_waddr_i),
    .push_data_i   (lsu_wdata_i),
    .pop_i         (w_pop),
    .cancel_i      (w_ex_wr),
    .cancel_addr_i (ex_waddr_i),
    .raddr_a_i     (w_fifo_raddr_a),
    .raddr_b_i     (w_fifo_raddr_b),
    .head_valid_o  (w_head_valid),
    .head_addr_o   (w_head_addr),
    .head_data_o   (w_head_data),
    .count_o       (w_count),
    .head_ptr_o    (w_head_ptr),
    .entry_data_o  (w_entry_data),
    .match_a_o     (w_match_a),
    .match_b_o     (w_match_b)
  );

  always_comb begin
    w_nxt_we   = 1'b0;
    w_nxt_addr = r_rf_waddr;
    w_nxt_data = r_rf_wdata;
    if (ex_valid_i) begin
      w_nxt_we   = w_ex_wr;
      w_nxt_addr = ex_waddr_i;
      w_nxt_data = ex_wdata_i;
    end else if (w_pop) begin
      w_nxt_we   = w_head_valid;
      w_nxt_addr = w_head_addr;
      w_nxt_data = w_head_data;
    end else if (w_bypass) begin
      w_nxt_we   = !w_lsu_drop;
      w_nxt_addr = lsu_waddr_i;
      w_nxt_data = lsu_wdata_i;
    end
  end

  // Address/data hold across idle cycles; only the enable is cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_nxt_we;
      if (w_nxt_we) begin
        r_rf_waddr <= w_nxt_addr;
        r_rf_wdata <= w_nxt_data;
      end
    end
  end

  assign rf_we_o    = r_rf_we;
  assign rf_waddr_o = r_rf_waddr;
  assign rf_wdata_o = r_rf_wdata;
  assign busy_o     = !w_empty || r_rf_we;

`ifdef IBEX_RF_WB_FWD_EN
  logic                 w_hit_a;
  logic                 w_hit_b;
  logic [DataWidth-1:0] w_fdata_a;
  logic [DataWidth-1:0] w_fdata_b;
  logic [PtrW:0]        w_slot;

  assign w_fifo_raddr_a = raddr_a_i;
  assign w_fifo_raddr_b = raddr_b_i;

  // Walk oldest to youngest so the youngest buffer hit wins; the output
  // register is the lowest-priority source.
  always_comb begin
    w_hit_a   = 1'b0;
    w_hit_b   = 1'b0;
    w_fdata_a = '0;
    w_fdata_b = '0;
    w_slot    = '0;
    if (r_rf_we && rf_addr_eq(r_rf_waddr, raddr_a_i, RV32E) &&
        !rf_addr_is_x0(raddr_a_i, RV32E)) begin
      w_hit_a   = 1'b1;
      w_fdata_a = r_rf_wdata;
    end
    if (r_rf_we && rf_addr_eq(r_rf_waddr, raddr_b_i, RV32E) &&
        !rf_addr_is_x0(raddr_b_i, RV32E)) begin
      w_hit_b   = 1'b1;
      w_fdata_b = r_rf_wdata;
    end
    for (int unsigned k = 0; k < Depth; k++) begin
      w_slot = {1'b0, w_head_ptr} + (PtrW + 1)'(k);
      if (w_slot >= (PtrW + 1)'(Depth)) begin
        w_slot = w_slot - (PtrW + 1)'(Depth);
      end
      if (CntW'(k) < w_count) begin
        if (w_match_a[w_slot[PtrW-1:0]]) begin
          w_hit_a   = 1'b1;
          w_fdata_a = w_entry_data[w_slot[PtrW-1:0]];
        end
        if (w_match_b[w_slot[PtrW-1:0]]) begin
          w_hit_b   = 1'b1;
          w_fdata_b = w_entry_data[w_slot[PtrW-1:0]];
        end
      end
    end
  end

  assign fwd_hit_a_o  = w_hit_a;
  assign fwd_hit_b_o  = w_hit_b;
  assign fwd_data_a_o = w_fdata_a;
  assign fwd_data_b_o = w_fdata_b;
`else
  logic w_unused_fwd;

  assign w_fifo_raddr_a = '0;
  assign w_fifo_raddr_b = '0;
  assign w_unused_fwd   = ^{raddr_a_i, raddr_b_i, w_match_a, w_match_b,
                            w_entry_data, w_head_ptr};
  assign fwd_hit_a_o    = 1'b0;
  assign fwd_hit_b_o    = 1'b0;
  assign fwd_data_a_o   = '0;
  assign fwd_data_b_o   = '0;
`endif

endmodule
